axi_slave: RTL and testbench
============================

AXI_SLAVE -- requirements
Module: axi_slave

Interface
Parameters: none; address and data are fixed at 32 bit, and only INCR bursts of 4-byte beats are supported.
REQ-001 clock  input  1  single clock; all state changes on the rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 s_axi_awaddr  input  32  write burst start address.
REQ-004 s_axi_awlen  input  8  write beats minus 1.
REQ-005 s_axi_awvalid  input  1  write address valid.
REQ-006 s_axi_awready  output  1  write address accepted.
REQ-007 s_axi_wdata  input  32  write beat data.
REQ-008 s_axi_wstrb  input  4  write byte enables.
REQ-009 s_axi_wlast  input  1  last write beat.
REQ-010 s_axi_wvalid  input  1  write data valid.
REQ-011 s_axi_wready  output  1  write data accepted.
REQ-012 s_axi_bresp  output  2  write response: OKAY=0, SLVERR=2.
REQ-013 s_axi_bvalid  output  1  write response valid.
REQ-014 s_axi_bready  input  1  write response taken.
REQ-015 s_axi_araddr  input  32  read burst start address.
REQ-016 s_axi_arlen  input  8  read beats minus 1.
REQ-017 s_axi_arvalid  input  1  read address valid.
REQ-018 s_axi_arready  output  1  read address accepted.
REQ-019 s_axi_rdata  output  32  read beat data.
REQ-020 s_axi_rresp  output  2  read beat response.
REQ-021 s_axi_rlast  output  1  last read beat.
REQ-022 s_axi_rvalid  output  1  read beat valid.
REQ-023 s_axi_rready  input  1  read beat taken.
REQ-024 mem_valid  output  1  one-cycle native request pulse.
REQ-025 mem_addr  output  32  native word address.
REQ-026 mem_wdata  output  32  native write data.
REQ-027 mem_wstrb  output  4  native byte enables; 0 means read.
REQ-028 mem_rdata  input  32  native read data, sampled when mem_ready=1.
REQ-029 mem_ready  input  1  one-cycle native completion pulse.

Function
REQ-030 The block SHALL implement the FSM states IDLE, W_DATA, W_MEM, W_RESP, R_MEM and R_DATA, with one transaction outstanding at a time.
REQ-031 In IDLE, awready SHALL equal awvalid&&(!arvalid||prio_wr) and arready SHALL equal arvalid&&!awready (combinational); prio_wr SHALL toggle after each granted burst, so simultaneous requests alternate between write and read.
REQ-032 On an AW/AR handshake, the block SHALL latch addr, len and err=(addr[1:0]!=0), clear beat_cnt, and go to W_DATA or R_MEM respectively.
REQ-033 W_DATA SHALL hold wready=1; a W handshake SHALL latch wdata/wstrb and go to W_MEM.
REQ-034 A W beat with wlast!=(beat_cnt==len) SHALL set err.
REQ-035 W_MEM SHALL pulse mem_valid in its first cycle only (mem_wstrb=wstrb) when err=0, and wait for mem_ready; when err=1 it SHALL skip the native access and complete in 1 cycle.
REQ-036 R_MEM SHALL pulse mem_valid in its first cycle only (mem_wstrb=0) when err=0, and latch mem_rdata on mem_ready; when err=1 it SHALL return rdata=0 without a native access.
REQ-037 Each completed beat SHALL increment addr by 4 (32-bit wrap) and beat_cnt by 1; when beat_cnt==len, a write SHALL go to W_RESP and a read SHALL clear the burst; otherwise a write SHALL return to W_DATA.
REQ-038 R_DATA SHALL hold rvalid, rdata, rresp and rlast=(beat_cnt==len) stable until rready; then it SHALL go to R_MEM, or to IDLE after the last beat.
REQ-039 W_RESP SHALL hold bvalid=1 with bresp=err?2:0 until bready, then go to IDLE.
REQ-040 The minimum native-to-AXI latency SHALL be 1 cycle from mem_ready to rvalid or to the next wready.
REQ-041 mem_ready pulses received outside W_MEM/R_MEM SHALL be ignored.

Reset
REQ-042 While reset=0, the block SHALL force state=IDLE, prio_wr=1, err=0, all counters 0, and all outputs 0, including mid-burst; no response SHALL be issued for an aborted burst.

Structure
REQ-043 The FSM state enum and the AXI response codes SHALL be defined in the shared configure package; the block SHALL be a single module with no sub-modules.

Verification
REQ-044 Single write, awaddr=0x100, awlen=0, wdata=0xDEADBEEF, wstrb=0xF, mem_ready 2 cycles later -> one mem_valid pulse with addr=0x100, then bresp=0.
REQ-045 Read burst, araddr=0x200, arlen=3, mem_rdata=addr -> rdata 0x200/0x204/0x208/0x20C, rlast on beat 4 only.
REQ-046 awvalid and arvalid asserted together on consecutive bursts -> the grant order is write, read, write.
REQ-047 awaddr=0x102 -> no mem_valid, bresp=2; araddr=0x106, arlen=1 -> 2 beats of rdata=0, rresp=2.
REQ-048 wlast asserted on beat 1 of an awlen=2 burst -> bresp=2; rready held low for 5 cycles -> rdata stays stable; reset=0 mid-burst -> all outputs 0 and state IDLE.

Source files
------------

// File: rtl/axi_slave_pkg.sv
// Shared definitions for the AXI-to-native bridge: FSM states and AXI response codes.
package axi_slave_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_W_DATA,
      ST_W_MEM,
      ST_W_RESP,
      ST_R_MEM,
      ST_R_DATA
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic [1:0] resp_of(input logic err);
      return err ? RESP_SLVERR : RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_slave.sv
// AXI INCR-burst slave that turns each 4-byte beat into one native memory request.
// One burst outstanding at a time; simultaneous write/read requests alternate.
module axi_slave
   import axi_slave_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] s_axi_awaddr,
   input  logic [7:0]  s_axi_awlen,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wlast,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic [31:0] s_axi_araddr,
   input  logic [7:0]  s_axi_arlen,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rlast,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   state_t      state_reg, state_next;
   logic        prio_wr_reg, prio_wr_next;
   logic [31:0] addr_reg, addr_next;
   logic [7:0]  len_reg, len_next;
   logic [7:0]  beat_cnt_reg, beat_cnt_next;
   logic        err_reg, err_next;
   logic        first_reg, first_next;
   logic [31:0] wdata_reg, wdata_next;
   logic [3:0]  wstrb_reg, wstrb_next;
   logic [31:0] rdata_reg, rdata_next;
   logic        aw_grant, ar_grant;
   logic        last_beat;

   assign last_beat = (beat_cnt_reg == len_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         prio_wr_reg  <= 1'b1;
         addr_reg     <= '0;
         len_reg      <= '0;
         beat_cnt_reg <= '0;
         err_reg      <= 1'b0;
         first_reg    <= 1'b0;
         wdata_reg    <= '0;
         wstrb_reg    <= '0;
         rdata_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         prio_wr_reg  <= prio_wr_next;
         addr_reg     <= addr_next;
         len_reg      <= len_next;
         beat_cnt_reg <= beat_cnt_next;
         err_reg      <= err_next;
         first_reg    <= first_next;
         wdata_reg    <= wdata_next;
         wstrb_reg    <= wstrb_next;
         rdata_reg    <= rdata_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      prio_wr_next  = prio_wr_reg;
      addr_next     = addr_reg;
      len_next      = len_reg;
      beat_cnt_next = beat_cnt_reg;
      err_next      = err_reg;
      first_next    = first_reg;
      wdata_next    = wdata_reg;
      wstrb_next    = wstrb_reg;
      rdata_next    = rdata_reg;
      aw_grant      = 1'b0;
      ar_grant      = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            aw_grant = s_axi_awvalid && (!s_axi_arvalid || prio_wr_reg);
            ar_grant = s_axi_arvalid && !aw_grant;
            if (aw_grant) begin
               addr_next     = s_axi_awaddr;
               len_next      = s_axi_awlen;
               err_next      = (s_axi_awaddr[1:0] != 2'b00);
               beat_cnt_next = '0;
               prio_wr_next  = !prio_wr_reg;
               state_next    = ST_W_DATA;
            end else if (ar_grant) begin
               addr_next     = s_axi_araddr;
               len_next      = s_axi_arlen;
               err_next      = (s_axi_araddr[1:0] != 2'b00);
               beat_cnt_next = '0;
               prio_wr_next  = !prio_wr_reg;
               first_next    = 1'b1;
               state_next    = ST_R_MEM;
            end
         end
         ST_W_DATA: begin
            if (s_axi_wvalid) begin
               wdata_next = s_axi_wdata;
               wstrb_next = s_axi_wstrb;
               if (s_axi_wlast != last_beat)
                  err_next = 1'b1;
               first_next = 1'b1;
               state_next = ST_W_MEM;
            end
         end
         ST_W_MEM: begin
            first_next = 1'b0;
            // An errored burst still consumes every beat but never touches memory.
            if (err_reg || mem_ready) begin
               addr_next     = addr_reg + 32'd4;
               beat_cnt_next = beat_cnt_reg + 8'd1;
               state_next    = last_beat ? ST_W_RESP : ST_W_DATA;
            end
         end
         ST_W_RESP: begin
            if (s_axi_bready)
               state_next = ST_IDLE;
         end
         ST_R_MEM: begin
            first_next = 1'b0;
            if (err_reg) begin
               rdata_next = '0;
               state_next = ST_R_DATA;
            end else if (mem_ready) begin
               rdata_next = mem_rdata;
               state_next = ST_R_DATA;
            end
         end
         ST_R_DATA: begin
            if (s_axi_rready) begin
               if (last_beat) begin
                  state_next = ST_IDLE;
               end else begin
                  addr_next     = addr_reg + 32'd4;
                  beat_cnt_next = beat_cnt_reg + 8'd1;
                  first_next    = 1'b1;
                  state_next    = ST_R_MEM;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Address grants are combinational, so gate them with reset to keep outputs low.
   assign s_axi_awready = rst_n && aw_grant;
   assign s_axi_arready = rst_n && ar_grant;
   assign s_axi_wready  = (state_reg == ST_W_DATA);
   assign s_axi_bvalid  = (state_reg == ST_W_RESP);
   assign s_axi_bresp   = s_axi_bvalid ? resp_of(err_reg) : RESP_OKAY;
   assign s_axi_rvalid  = (state_reg == ST_R_DATA);
   assign s_axi_rdata   = s_axi_rvalid ? rdata_reg : '0;
   assign s_axi_rresp   = s_axi_rvalid ? resp_of(err_reg) : RESP_OKAY;
   assign s_axi_rlast   = s_axi_rvalid && last_beat;

   assign mem_valid = ((state_reg == ST_W_MEM) || (state_reg == ST_R_MEM)) && first_reg && !err_reg;
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;
   assign mem_wstrb = (state_reg == ST_W_MEM) ? wstrb_reg : 4'h0;

endmodule

// File: tb/tb_axi_slave.sv
// Directed bench for axi_slave: a vector table of single bursts plus hand-written
// sequences for arbitration, backpressure, latency and mid-burst reset.
module tb_axi_slave;
   import axi_slave_pkg::*;

   localparam int TMO = 200;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr;
   logic [7:0]  s_axi_awlen, s_axi_arlen;
   logic        s_axi_awvalid, s_axi_wlast, s_axi_wvalid, s_axi_bready;
   logic        s_axi_arvalid, s_axi_rready;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready;
   logic        s_axi_rlast, s_axi_rvalid;
   logic [1:0]  s_axi_bresp, s_axi_rresp;
   logic [31:0] s_axi_rdata;
   logic        mem_valid, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   always #5 clk = ~clk;

   axi_slave dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   int          total = 0;
   int          passed = 0;
   int          cyc = 0;

   // Native memory responder: answers each request after resp_delay extra cycles
   // with read data equal to the request address.
   int          resp_delay = 0;
   int          nmem = 0;
   int          rdy_cyc = 0;
   int          cnt = 0;
   bit          pend = 0;
   bit          mv_prev = 0;
   bit          mv_multi = 0;
   logic [31:0] lat_addr = '0, lat_wdata = '0, resp_rdata = '0;
   logic [3:0]  lat_wstrb = '0;
   logic        resp_ready = 1'b0;
   logic        spur_ready = 1'b0;

   assign mem_ready = resp_ready | spur_ready;
   assign mem_rdata = spur_ready ? 32'hBAD0BAD0 : resp_rdata;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      resp_ready = 1'b0;
      if (mem_valid && mv_prev) mv_multi = 1'b1;
      mv_prev = mem_valid;
      if (pend) begin
         if (cnt == 0) begin
            resp_ready = 1'b1;
            resp_rdata = lat_addr;
            pend       = 1'b0;
            rdy_cyc    = cyc;
         end else begin
            cnt = cnt - 1;
         end
      end
      if (mem_valid) begin
         nmem      = nmem + 1;
         lat_addr  = mem_addr;
         lat_wdata = mem_wdata;
         lat_wstrb = mem_wstrb;
         pend      = 1'b1;
         cnt       = resp_delay;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctrl"}, {22'd0, s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
          s_axi_arready, s_axi_rresp, s_axi_rlast, s_axi_rvalid, mem_valid}, 32'd0);
      chk({tag, "_rdata"}, s_axi_rdata, 32'd0);
      chk({tag, "_maddr"}, mem_addr, 32'd0);
      chk({tag, "_mwdata"}, {mem_wdata[31:4], mem_wdata[3:0] | mem_wstrb}, 32'd0);
   endtask

   task automatic aw_xfer(input logic [31:0] a, input logic [7:0] l);
      int n = 0;
      s_axi_awaddr = a; s_axi_awlen = l; s_axi_awvalid = 1'b1;
      #1;
      while (!s_axi_awready && n < TMO) begin @(negedge clk); #1; n++; end
      if (n >= TMO) chk("aw_timeout", {31'd0, s_axi_awready}, 32'd1);
      @(negedge clk); s_axi_awvalid = 1'b0;
   endtask

   task automatic ar_xfer(input logic [31:0] a, input logic [7:0] l);
      int n = 0;
      s_axi_araddr = a; s_axi_arlen = l; s_axi_arvalid = 1'b1;
      #1;
      while (!s_axi_arready && n < TMO) begin @(negedge clk); #1; n++; end
      if (n >= TMO) chk("ar_timeout", {31'd0, s_axi_arready}, 32'd1);
      @(negedge clk); s_axi_arvalid = 1'b0;
   endtask

   task automatic w_xfer(input logic [31:0] d, input logic [3:0] s, input logic last);
      int n = 0;
      s_axi_wdata = d; s_axi_wstrb = s; s_axi_wlast = last; s_axi_wvalid = 1'b1;
      #1;
      while (!s_axi_wready && n < TMO) begin @(negedge clk); #1; n++; end
      if (n >= TMO) chk("w_timeout", {31'd0, s_axi_wready}, 32'd1);
      @(negedge clk); s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
   endtask

   task automatic b_take(output logic [1:0] resp);
      int n = 0;
      s_axi_bready = 1'b1;
      #1;
      while (!s_axi_bvalid && n < TMO) begin @(negedge clk); #1; n++; end
      if (n >= TMO) chk("b_timeout", {31'd0, s_axi_bvalid}, 32'd1);
      resp = s_axi_bresp;
      @(negedge clk); s_axi_bready = 1'b0;
   endtask

   task automatic r_take(output logic [31:0] d, output logic [1:0] rs, output logic l, output int vc);
      int n = 0;
      s_axi_rready = 1'b1;
      #1;
      while (!s_axi_rvalid && n < TMO) begin @(negedge clk); #1; n++; end
      if (n >= TMO) chk("r_timeout", {31'd0, s_axi_rvalid}, 32'd1);
      d = s_axi_rdata; rs = s_axi_rresp; l = s_axi_rlast; vc = cyc;
      @(negedge clk); s_axi_rready = 1'b0;
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [31:0] data;
      logic [3:0]  strb;
      int          delay;
      logic [1:0]  resp;
      int          nmem;
      logic [31:0] last_addr;
      logic [31:0] rbase;
      logic [31:0] rstep;
   } vec_t;

   vec_t vecs [7];

   initial begin
      logic [1:0]  resp;
      logic [31:0] d;
      logic        l;
      int          vc, n0, n;
      bit          got_wr;

      vecs[0] = '{1'b1, 32'h0000_0100, 8'd0, 32'hDEAD_BEEF, 4'hF, 1, 2'd0, 1, 32'h0000_0100, 32'h0, 32'h0};
      vecs[1] = '{1'b0, 32'h0000_0200, 8'd3, 32'h0,         4'h0, 1, 2'd0, 4, 32'h0000_020C, 32'h0000_0200, 32'd4};
      vecs[2] = '{1'b1, 32'h0000_0102, 8'd0, 32'h1234_5678, 4'h3, 0, 2'd2, 0, 32'h0, 32'h0, 32'h0};
      vecs[3] = '{1'b0, 32'h0000_0106, 8'd1, 32'h0,         4'h0, 0, 2'd2, 0, 32'h0, 32'h0, 32'd0};
      vecs[4] = '{1'b1, 32'hFFFF_FFFC, 8'd1, 32'hA5A5_A5A5, 4'h5, 0, 2'd0, 2, 32'h0000_0000, 32'h0, 32'h0};
      vecs[5] = '{1'b0, 32'hFFFF_FFFC, 8'd1, 32'h0,         4'h0, 2, 2'd0, 2, 32'h0000_0000, 32'hFFFF_FFFC, 32'd4};
      vecs[6] = '{1'b1, 32'h0000_0040, 8'd2, 32'h1122_3344, 4'h8, 3, 2'd0, 3, 32'h0000_0048, 32'h0, 32'h0};

      rst_n = 1'b0;
      s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awvalid = 1'b1;
      s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
      s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arvalid = 1'b1;
      s_axi_rready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk_zero("reset");
      s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 7; v++) begin
         resp_delay = vecs[v].delay;
         n0 = nmem;
         if (vecs[v].wr) begin
            aw_xfer(vecs[v].addr, vecs[v].len);
            for (int b = 0; b <= int'(vecs[v].len); b++)
               w_xfer(vecs[v].data, vecs[v].strb, b == int'(vecs[v].len));
            b_take(resp);
            chk($sformatf("v%0d_bresp", v), {30'd0, resp}, {30'd0, vecs[v].resp});
         end else begin
            ar_xfer(vecs[v].addr, vecs[v].len);
            for (int b = 0; b <= int'(vecs[v].len); b++) begin
               r_take(d, resp, l, vc);
               chk($sformatf("v%0d_b%0d_rdata", v, b), d, vecs[v].rbase + vecs[v].rstep * b);
               chk($sformatf("v%0d_b%0d_rresp", v, b), {30'd0, resp}, {30'd0, vecs[v].resp});
               chk($sformatf("v%0d_b%0d_rlast", v, b), {31'd0, l}, {31'd0, b == int'(vecs[v].len)});
            end
         end
         chk($sformatf("v%0d_nmem", v), nmem - n0, vecs[v].nmem);
         if (vecs[v].nmem > 0) begin
            chk($sformatf("v%0d_maddr", v), lat_addr, vecs[v].last_addr);
            chk($sformatf("v%0d_mwstrb", v), {28'd0, lat_wstrb}, {28'd0, vecs[v].strb});
            if (vecs[v].wr) chk($sformatf("v%0d_mwdata", v), lat_wdata, vecs[v].data);
         end
      end

      // mem_ready to rvalid in one cycle
      resp_delay = 0;
      ar_xfer(32'h0000_0300, 8'd0);
      r_take(d, resp, l, vc);
      chk("lat_rdata", d, 32'h0000_0300);
      chk("lat_cycles", vc - rdy_cyc, 32'd1);

      // rready held low: beat stays stable and a stray mem_ready is ignored
      resp_delay = 1;
      ar_xfer(32'h0000_0500, 8'd1);
      n = 0;
      #1;
      while (!s_axi_rvalid && n < TMO) begin @(negedge clk); #1; n++; end
      if (n >= TMO) chk("hold_timeout", {31'd0, s_axi_rvalid}, 32'd1);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("hold%0d_beat", k), {s_axi_rdata[31:3], s_axi_rvalid, s_axi_rlast, 1'b0},
             {29'h0000_00A0, 1'b1, 1'b0, 1'b0});
         @(negedge clk);
         spur_ready = (k == 1);
         #1;
      end
      spur_ready = 1'b0;
      r_take(d, resp, l, vc);
      chk("hold_b0_rdata", d, 32'h0000_0500);
      chk("hold_b0_rlast", {31'd0, l}, 32'd0);
      r_take(d, resp, l, vc);
      chk("hold_b1_rdata", d, 32'h0000_0504);
      chk("hold_b1_rlast", {31'd0, l}, 32'd1);

      // wlast on the first beat of a 3-beat burst
      n0 = nmem;
      aw_xfer(32'h0000_0600, 8'd2);
      w_xfer(32'h0000_00A1, 4'hF, 1'b1);
      w_xfer(32'h0000_00A2, 4'hF, 1'b0);
      w_xfer(32'h0000_00A3, 4'hF, 1'b1);
      b_take(resp);
      chk("early_wlast_bresp", {30'd0, resp}, 32'd2);
      chk("early_wlast_nmem", nmem - n0, 32'd0);

      // reset in the middle of a write burst
      aw_xfer(32'h0000_0800, 8'd3);
      w_xfer(32'h0000_0011, 4'hF, 1'b0);
      repeat (6) @(negedge clk);
      s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
      rst_n = 1'b0;
      #1;
      chk_zero("midrst");
      chk("midrst_state", {29'd0, dut.state_reg}, {29'd0, ST_IDLE});
      @(negedge clk);
      s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("midrst_no_resp", {30'd0, s_axi_bvalid, s_axi_wready}, 32'd0);

      // simultaneous requests alternate write, read, write starting from reset priority
      @(negedge clk);
      resp_delay = 0;
      for (int g = 0; g < 3; g++) begin
         s_axi_awaddr = 32'h0000_0900 + 32'(g * 16); s_axi_awlen = 8'd0;
         s_axi_araddr = 32'h0000_0A00 + 32'(g * 16); s_axi_arlen = 8'd0;
         s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
         n = 0;
         #1;
         while (!(s_axi_awready || s_axi_arready) && n < TMO) begin @(negedge clk); #1; n++; end
         if (n >= TMO) chk("arb_timeout", {31'd0, s_axi_awready | s_axi_arready}, 32'd1);
         got_wr = s_axi_awready;
         chk($sformatf("arb_g%0d_write", g), {31'd0, got_wr}, {31'd0, g != 1});
         @(negedge clk);
         s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
         if (got_wr) begin
            w_xfer(32'h0000_0C00 + 32'(g), 4'hF, 1'b1);
            b_take(resp);
         end else begin
            r_take(d, resp, l, vc);
            chk("arb_rdata", d, 32'h0000_0A10);
         end
      end

      chk("mem_valid_single_pulse", {31'd0, mv_multi}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
